d_latch: RTL and testbench



---
 rtl/d_latch_bit.sv | 17 +
 rtl/d_latch.sv | 21 ++
 tb/tb_d_latch.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/d_latch_bit.sv
// Single-bit level-sensitive storage cell: transparent while clock is high, holds while low.
// reset_n clears the cell, but only while the cell is transparent.
module d_latch_bit (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    // A level-sensitive latch is the intended storage element here, not an accident of coding.
    always_latch begin
        if (clock) begin
            q <= reset_n ? d : 1'b0;
        end
    end

endmodule

// File: rtl/d_latch.sv
// WIDTH-bit phase-transparent holding register built from independent per-bit latch cells.
// The clear is level-sensitive and only acts during the transparent (clock high) phase.
module d_latch #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] data,
    input  logic             clock,
    input  logic             reset
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_latch_bit u_bit (
            .clock   (clock),
            .reset_n (reset),
            .d       (data[i]),
            .q       (out[i])
        );
    end

endmodule

// File: tb/tb_d_latch.sv
// Directed bench for d_latch at WIDTH=1 and WIDTH=8 with a behavioural reference and literal checks.
`timescale 1ns/100ps
module tb_d_latch;

    logic       clock;
    logic       reset;
    logic [0:0] data1;
    logic [0:0] out1;
    logic [7:0] data8;
    logic [7:0] out8;

    int n_checks = 0;
    int n_fail   = 0;

    logic       held1;
    logic [7:0] held8;
    bit         valid = 0;
    bit         done  = 0;

    d_latch #(.WIDTH(1)) dut1 (
        .out   (out1),
        .data  (data1),
        .clock (clock),
        .reset (reset)
    );

    d_latch #(.WIDTH(8)) dut8 (
        .out   (out8),
        .data  (data8),
        .clock (clock),
        .reset (reset)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: while clock is high the output is data (or zero under clear);
    // while low it is whatever was last seen during the high phase.
    initial begin
        #0.5;
        while (!done) begin
            if (clock === 1'b1) begin
                held1 = (reset === 1'b1) ? data1[0] : 1'b0;
                held8 = (reset === 1'b1) ? data8 : 8'h00;
                valid = 1;
            end
            if (valid) begin
                check8("model_w1", {7'b0, out1}, {7'b0, held1});
                check8("model_w8", out8, held8);
            end
            #1;
        end
    end

    task automatic step(input logic c, input logic r, input logic d1, input logic [7:0] d8);
        clock = c;
        reset = r;
        data1 = d1;
        data8 = d8;
        #1;
    endtask

    task automatic lit(input string name, input logic e1, input logic [7:0] e8);
        #0.5;
        check8({name, "_w1"}, {7'b0, out1}, {7'b0, e1});
        check8({name, "_w8"}, out8, e8);
        #0.5;
    endtask

    initial begin
        // Clear while transparent at power-up
        step(1, 0, 1, 8'hFF);
        lit("clear_init", 1'b0, 8'h00);

        // Transparent follow
        step(1, 1, 0, 8'h3C);
        lit("follow0", 1'b0, 8'h3C);
        step(1, 1, 1, 8'hC3);
        lit("follow1", 1'b1, 8'hC3);
        step(1, 1, 0, 8'h81);
        lit("follow2", 1'b0, 8'h81);

        // Hold through data change in the low phase
        step(1, 1, 1, 8'hA5);
        step(0, 1, 1, 8'hA5);
        step(0, 1, 0, 8'h00);
        lit("hold", 1'b1, 8'hA5);
        step(1, 1, 0, 8'h00);
        lit("hold_release", 1'b0, 8'h00);

        // Clear requested during the low phase waits for the next high phase
        step(1, 1, 1, 8'h5A);
        step(0, 1, 1, 8'h5A);
        step(0, 0, 1, 8'h5A);
        lit("clear_ignored_low", 1'b1, 8'h5A);
        step(1, 0, 1, 8'h5A);
        lit("clear_high", 1'b0, 8'h00);
        step(1, 1, 1, 8'h5A);
        lit("clear_release", 1'b1, 8'h5A);

        // Reset pulse entirely inside the low phase is lost
        step(0, 1, 1, 8'h5A);
        step(0, 0, 0, 8'hC3);
        step(0, 1, 0, 8'hC3);
        lit("hidden_pulse", 1'b1, 8'h5A);
        step(1, 1, 0, 8'hC3);
        lit("after_pulse", 1'b0, 8'hC3);

        // Clear asserted together with the rising edge
        step(1, 1, 1, 8'hF0);
        step(0, 1, 1, 8'hF0);
        step(1, 0, 1, 8'hF0);
        lit("clear_at_rise", 1'b0, 8'h00);

        // Periodic clock, period 4, data changing every 4 units
        reset = 1;
        data1 = 0;
        data8 = 8'h00;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    clock = 1;
                    #2;
                    clock = 0;
                    #2;
                end
            end
            begin
                #4  data1 = 1; data8 = 8'h11;
                #4  data1 = 0; data8 = 8'h22;
                #4  data1 = 1; data8 = 8'h33;
                #4  data1 = 0; data8 = 8'h44;
            end
            begin
                #6.5  check8("run_t6",  {7'b0, out1}, 8'h01);
                      check8("run_t6_w8", out8, 8'h11);
                #4    check8("run_t10", {7'b0, out1}, 8'h00);
                      check8("run_t10_w8", out8, 8'h22);
                #4    check8("run_t14", {7'b0, out1}, 8'h01);
                      check8("run_t14_w8", out8, 8'h33);
                #4    check8("run_t18", {7'b0, out1}, 8'h00);
                      check8("run_t18_w8", out8, 8'h44);
            end
        join

        done = 1;
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
